// File: rtl/noc_pkg.sv
// Shared router definitions: port direction indices, port count and the
// credit-controller drain FSM state encoding.
package noc_pkg;
   localparam int DIR_N     = 0;
   localparam int DIR_S     = 1;
   localparam int DIR_W     = 2;
   localparam int DIR_E     = 3;
   localparam int DIR_L     = 4;
   localparam int NUM_PORTS = 5;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      DRAINED
   } cc_state_e;
endpackage

// File: rtl/credit_counter.sv
// One output port's saturating credit counter. With CREDIT_ERR_CHECK_EN defined
// a sticky error flop records underflow/overflow attempts; otherwise err_o is 0.
module credit_counter #(
   parameter int BUF_DEPTH = 4,
   parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          dec_i,
   input  logic          ret_i,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          err_o
);
   localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

   logic [CW-1:0] count_d;
   logic [CW-1:0] count_q;

   // Simultaneous dec+ret cancels out at any count, so only the one-sided
   // cases need the saturation guards.
   always_comb begin
      count_d = count_q;
      if (dec_i && !ret_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end else if (ret_i && !dec_i && (count_q != FULL)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= FULL;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign full_o  = (count_q == FULL);

`ifdef CREDIT_ERR_CHECK_EN
   logic underflow;
   logic overflow;
   logic err_d;
   logic err_q;

   assign underflow = dec_i & ~ret_i & (count_q == '0);
   assign overflow  = ret_i & ~dec_i & (count_q == FULL);

   always_comb begin
      err_d = err_q | underflow | overflow;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif
endmodule

// File: rtl/credit_counter_ctrl.sv
// Per-port downstream credit tracking plus a drain handshake for quiescing the
// router. Optional sticky over/underflow flags via CREDIT_ERR_CHECK_EN.
module credit_counter_ctrl
   import noc_pkg::*;
#(
   parameter  int BUF_DEPTH = 4,
   localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_PORTS-1:0]    dec_i,
   input  logic [NUM_PORTS-1:0]    ret_i,
   input  logic                    drain_req_i,
   output logic [NUM_PORTS-1:0]    credit_o,
   output logic [NUM_PORTS*CW-1:0] count_o,
   output logic                    drain_ack_o,
   output logic [NUM_PORTS-1:0]    err_o
);
   cc_state_e            state_d;
   cc_state_e            state_q;
   logic                 drain_ack_d;
   logic                 drain_ack_q;
   logic [NUM_PORTS-1:0] full;
   logic [NUM_PORTS-1:0] nonzero;

   for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
      credit_counter #(
         .BUF_DEPTH (BUF_DEPTH),
         .CW        (CW)
      ) u_cnt (
         .clk     (clk),
         .reset   (reset),
         .dec_i   (dec_i[gi]),
         .ret_i   (ret_i[gi]),
         .count_o (count_o[gi*CW +: CW]),
         .full_o  (full[gi]),
         .err_o   (err_o[gi])
      );
      assign nonzero[gi] = (count_o[gi*CW +: CW] != '0);
   end

   // Dropping the request always wins; the drained check only matters while
   // the request is still held.
   always_comb begin
      state_d = state_q;
      case (state_q)
         RUN:     if (drain_req_i) state_d = DRAIN;
         DRAIN:   if (!drain_req_i) state_d = RUN;
                  else if (&full) state_d = DRAINED;
         DRAINED: if (!drain_req_i) state_d = RUN;
         default: state_d = RUN;
      endcase
      drain_ack_d = (state_d == DRAINED);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= RUN;
         drain_ack_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         drain_ack_q <= drain_ack_d;
      end
   end

   assign credit_o    = nonzero & {NUM_PORTS{state_q == RUN}};
   assign drain_ack_o = drain_ack_q;
endmodule

// File: tb/tb_credit_counter_ctrl.sv
// Directed bench for credit_counter_ctrl; expected error flags follow
// CREDIT_ERR_CHECK_EN when the bench is built with the same define.
module tb_credit_counter_ctrl;
   localparam int CW = 3;

`ifdef CREDIT_ERR_CHECK_EN
   localparam logic ERR_EN = 1'b1;
`else
   localparam logic ERR_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    dec_i;
   logic [4:0]    ret_i;
   logic          drain_req_i;
   logic [4:0]    credit_o;
   logic [5*CW-1:0] count_o;
   logic          drain_ack_o;
   logic [4:0]    err_o;

   int tests = 0;
   int fails = 0;

   credit_counter_ctrl #(.BUF_DEPTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .dec_i       (dec_i),
      .ret_i       (ret_i),
      .drain_req_i (drain_req_i),
      .credit_o    (credit_o),
      .count_o     (count_o),
      .drain_ack_o (drain_ack_o),
      .err_o       (err_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [CW-1:0] cnt(input int p);
      return count_o[p*CW +: CW];
   endfunction

   task automatic test_reset();
      reset = 1'b0; dec_i = '0; ret_i = '0; drain_req_i = 1'b0;
      tick();
      reset = 1'b1;
      repeat (3) tick();
      tests++;
      if (count_o !== {5{3'd4}}) begin
         fails++; $display("FAIL reset_count: got %h expected %h", count_o, {5{3'd4}});
      end
      tests++;
      if (credit_o !== 5'b11111) begin
         fails++; $display("FAIL reset_credit: got %b expected 11111", credit_o);
      end
      tests++;
      if (drain_ack_o !== 1'b0) begin
         fails++; $display("FAIL reset_ack: got %b expected 0", drain_ack_o);
      end
      tests++;
      if (err_o !== 5'b00000) begin
         fails++; $display("FAIL reset_err: got %b expected 00000", err_o);
      end
      $display("[TB] test_reset done");
   endtask

   task automatic test_underflow();
      for (int i = 0; i < 4; i++) begin
         dec_i = 5'b00001;
         tick();
         dec_i = '0;
         tests++;
         if (cnt(0) !== 3'(3 - i)) begin
            fails++; $display("FAIL dec_n_count[%0d]: got %0d expected %0d", i, cnt(0), 3 - i);
         end
         tests++;
         if (credit_o[0] !== (i < 3)) begin
            fails++; $display("FAIL dec_n_credit[%0d]: got %b expected %b", i, credit_o[0], (i < 3));
         end
      end
      dec_i = 5'b00001;
      tick();
      dec_i = '0;
      tests++;
      if (cnt(0) !== 3'd0) begin
         fails++; $display("FAIL underflow_count: got %0d expected 0", cnt(0));
      end
      tests++;
      if (err_o[0] !== ERR_EN) begin
         fails++; $display("FAIL underflow_err: got %b expected %b", err_o[0], ERR_EN);
      end
      $display("[TB] test_underflow done");
   endtask

   task automatic test_dec_ret_same();
      repeat (4) begin
         dec_i = 5'b01000;
         tick();
      end
      dec_i = 5'b01000; ret_i = 5'b01000;
      tick();
      dec_i = '0; ret_i = '0;
      tests++;
      if (cnt(3) !== 3'd0) begin
         fails++; $display("FAIL both_at_zero_count: got %0d expected 0", cnt(3));
      end
      tests++;
      if (err_o[3] !== 1'b0) begin
         fails++; $display("FAIL both_at_zero_err: got %b expected 0", err_o[3]);
      end
      tests++;
      if (credit_o[3] !== 1'b0) begin
         fails++; $display("FAIL e_zero_credit: got %b expected 0", credit_o[3]);
      end
      ret_i = 5'b01000;
      tick();
      ret_i = '0;
      tests++;
      if (cnt(3) !== 3'd1) begin
         fails++; $display("FAIL e_ret_count: got %0d expected 1", cnt(3));
      end
      tests++;
      if (credit_o[3] !== 1'b1) begin
         fails++; $display("FAIL e_ret_credit: got %b expected 1", credit_o[3]);
      end
      $display("[TB] test_dec_ret_same done");
   endtask

   task automatic test_overflow();
      ret_i = 5'b10000;
      tick();
      ret_i = '0;
      tests++;
      if (cnt(4) !== 3'd4) begin
         fails++; $display("FAIL overflow_count: got %0d expected 4", cnt(4));
      end
      tests++;
      if (err_o[4] !== ERR_EN) begin
         fails++; $display("FAIL overflow_err: got %b expected %b", err_o[4], ERR_EN);
      end
      // Both strobes at full must not flag anything on an untouched port.
      dec_i = 5'b00010; ret_i = 5'b00010;
      tick();
      dec_i = '0; ret_i = '0;
      tests++;
      if (cnt(1) !== 3'd4 || err_o[1] !== 1'b0) begin
         fails++; $display("FAIL both_at_full: got count %0d err %b expected 4 0", cnt(1), err_o[1]);
      end
      $display("[TB] test_overflow done");
   endtask

   task automatic test_drain();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tests++;
      if (err_o !== 5'b00000 || count_o !== {5{3'd4}}) begin
         fails++; $display("FAIL drain_prereset: got err %b count %h expected 00000 %h", err_o, count_o, {5{3'd4}});
      end
      dec_i = 5'b00100;
      tick();
      tick();
      // Request rises together with a dec that must still be counted.
      drain_req_i = 1'b1;
      tick();
      dec_i = '0;
      tests++;
      if (credit_o !== 5'b00000) begin
         fails++; $display("FAIL drain_credit: got %b expected 00000", credit_o);
      end
      tests++;
      if (cnt(2) !== 3'd1) begin
         fails++; $display("FAIL drain_dec_counted: got %0d expected 1", cnt(2));
      end
      for (int i = 0; i < 3; i++) begin
         ret_i = 5'b00100;
         tick();
         ret_i = '0;
         tests++;
         if (drain_ack_o !== 1'b0 || cnt(2) !== 3'(2 + i)) begin
            fails++; $display("FAIL drain_ret[%0d]: got ack %b count %0d expected 0 %0d", i, drain_ack_o, cnt(2), 2 + i);
         end
      end
      tick();
      tests++;
      if (drain_ack_o !== 1'b1) begin
         fails++; $display("FAIL drain_ack: got %b expected 1", drain_ack_o);
      end
      tests++;
      if (credit_o !== 5'b00000) begin
         fails++; $display("FAIL drained_credit: got %b expected 00000", credit_o);
      end
      drain_req_i = 1'b0;
      tick();
      tests++;
      if (drain_ack_o !== 1'b0 || credit_o !== 5'b11111) begin
         fails++; $display("FAIL drain_release: got ack %b credit %b expected 0 11111", drain_ack_o, credit_o);
      end
      // Abort from DRAIN before anything is home.
      dec_i = 5'b00001;
      tick();
      dec_i = '0;
      drain_req_i = 1'b1;
      tick();
      drain_req_i = 1'b0;
      tick();
      tests++;
      if (drain_ack_o !== 1'b0 || credit_o !== 5'b11111) begin
         fails++; $display("FAIL drain_abort: got ack %b credit %b expected 0 11111", drain_ack_o, credit_o);
      end
      $display("[TB] test_drain done");
   endtask

   task automatic test_reset_mid_drain();
      ret_i = 5'b00001;
      tick();
      ret_i = '0;
      repeat (3) begin
         dec_i = 5'b00010;
         tick();
      end
      dec_i = 5'b00001;
      tick();
      dec_i = '0;
      tick();
      dec_i = 5'b00001;
      tick();
      dec_i = 5'b00001;
      tick();
      dec_i = 5'b00001;
      tick();
      dec_i = 5'b00001;
      tick();
      dec_i = '0;
      drain_req_i = 1'b1;
      tick();
      tests++;
      if (cnt(1) !== 3'd1 || credit_o !== 5'b00000) begin
         fails++; $display("FAIL middrain_setup: got s_count %0d credit %b expected 1 00000", cnt(1), credit_o);
      end
      reset = 1'b0;
      dec_i = 5'b00010;
      ret_i = 5'b00100;
      tick();
      dec_i = '0; ret_i = '0;
      reset = 1'b1;
      tests++;
      if (count_o !== {5{3'd4}}) begin
         fails++; $display("FAIL middrain_reset_count: got %h expected %h", count_o, {5{3'd4}});
      end
      tests++;
      if (credit_o !== 5'b11111 || drain_ack_o !== 1'b0 || err_o !== 5'b00000) begin
         fails++; $display("FAIL middrain_reset_state: got credit %b ack %b err %b expected 11111 0 00000", credit_o, drain_ack_o, err_o);
      end
      tick();
      tests++;
      if (credit_o !== 5'b00000 || drain_ack_o !== 1'b0) begin
         fails++; $display("FAIL middrain_redrain: got credit %b ack %b expected 00000 0", credit_o, drain_ack_o);
      end
      tick();
      tests++;
      if (drain_ack_o !== 1'b1) begin
         fails++; $display("FAIL middrain_ack: got %b expected 1", drain_ack_o);
      end
      drain_req_i = 1'b0;
      tick();
      $display("[TB] test_reset_mid_drain done");
   endtask

   initial begin
      test_reset();
      test_underflow();
      test_dec_ret_same();
      test_overflow();
      test_drain();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
